// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and state encoding for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane steering, load lane select/extension and legality check
module lsu_align
  import lsu_pkg::*;
(
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic        o_legal,
  output logic [31:0] o_ld_data
);

  logic       w_code_ok;
  logic       w_aligned;
  logic [7:0] w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = 32'h0;
    case (i_funct3)
      F3_B: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_store_data[7:0]}};
      end
      F3_H: begin
        o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_store_data[15:0]}};
      end
      F3_W: begin
        o_wstrb = 4'b1111;
        o_wdata = i_store_data;
      end
      default: begin
        o_wstrb = 4'b0000;
        o_wdata = 32'h0;
      end
    endcase
  end

  // Unsigned widths exist only for loads; stores accept just B/H/W.
  always_comb begin
    w_code_ok = 1'b0;
    w_aligned = 1'b0;
    case (i_funct3)
      F3_B:  begin w_code_ok = 1'b1;        w_aligned = 1'b1;               end
      F3_H:  begin w_code_ok = 1'b1;        w_aligned = ~i_addr_lo[0];      end
      F3_W:  begin w_code_ok = 1'b1;        w_aligned = (i_addr_lo == 2'b00); end
      F3_BU: begin w_code_ok = ~i_is_store; w_aligned = 1'b1;               end
      F3_HU: begin w_code_ok = ~i_is_store; w_aligned = ~i_addr_lo[0];      end
      default: begin w_code_ok = 1'b0;      w_aligned = 1'b0;               end
    endcase
    o_legal = w_code_ok & w_aligned;
  end

  always_comb begin
    case (i_ld_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ld_data = {24'h0, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ld_data = {16'h0, w_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - RV32I load/store unit driving a req/gnt/rvalid data-memory bus
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic        lsu_err,
  output logic [31:0] data_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  lsu_state_e       r_state;
  lsu_state_e       w_next;
  logic             r_is_store;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic [31:0]      r_addr;
  logic [3:0]       r_wstrb;
  logic [31:0]      r_wdata;
  logic [31:0]      r_data_out;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_legal;
  logic [3:0]       w_wstrb;
  logic [31:0]      w_wdata;
  logic [31:0]      w_ld_data;
  logic             w_timeout;

  lsu_align u_align (
    .i_is_store   (is_store),
    .i_funct3     (funct3),
    .i_addr_lo    (addr[1:0]),
    .i_store_data (store_data),
    .i_ld_funct3  (r_funct3),
    .i_ld_addr_lo (r_addr_lo),
    .i_rdata      (mem_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_legal      (w_legal),
    .o_ld_data    (w_ld_data)
  );

  // The counter value is the number of REQ/WAIT cycles already spent; this is the last allowed one.
  assign w_timeout = (r_cnt >= TO_LAST);

  always_comb begin
    w_next  = r_state;
    stall   = 1'b0;
    mem_req = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          stall  = 1'b1;
          w_next = w_legal ? ST_REQ : ST_DONE;
        end
      end
      ST_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt) begin
          w_next = r_is_store ? ST_DONE : ST_WAIT;
        end else if (w_timeout) begin
          w_next = ST_DONE;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (mem_rvalid || w_timeout) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_is_store <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr_lo  <= 2'b00;
      r_addr     <= 32'h0;
      r_wstrb    <= 4'b0000;
      r_wdata    <= 32'h0;
      r_data_out <= 32'h0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (start) begin
            r_err <= ~w_legal;
            if (w_legal) begin
              r_is_store <= is_store;
              r_funct3   <= funct3;
              r_addr_lo  <= addr[1:0];
              r_addr     <= {addr[31:2], 2'b00};
              r_wstrb    <= w_wstrb;
              r_wdata    <= w_wdata;
            end
          end
        end
        ST_REQ: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (!mem_gnt && w_timeout) begin
            r_err <= 1'b1;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (mem_rvalid) begin
            r_data_out <= w_ld_data;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign done      = (r_state == ST_DONE);
  assign lsu_err   = done & r_err;
  assign mem_we    = mem_req & r_is_store;
  assign mem_addr  = r_addr;
  assign mem_wstrb = r_wstrb;
  assign mem_wdata = r_wdata;
  assign data_out  = r_data_out;

endmodule
